// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM states and alignment check for mem_access_unit
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] a);
    return size == 2'b11 || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and RAM port bundle of mem_access_unit
interface mem_access_unit_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_fault;
  logic [31:0]       resp_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_fault, resp_rdata, ram_we, ram_addr, ram_wdata
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_fault, resp_rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: picks the addressed byte/half out of a RAM word and extends it
module load_align import mem_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[8*addr +: 8];
  assign h = word[16*addr[1] +: 16];
  assign data = size == SZ_BYTE ? {{24{b[7] & ~is_unsigned}}, b} :
                size == SZ_HALF ? {{16{h[15] & ~is_unsigned}}, h} : word;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator with read-modify-write sub-word stores
module mem_access_unit import mem_pkg::*; #(
  parameter int ADDR_W = 10
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  state_e            state, state_nx;
  logic              we_q, uns_q, fault_q, accept;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, word_q, merged, load_val;
  assign bus.req_ready = state == IDLE && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        fault_q <= is_misaligned(bus.req_size, bus.req_addr[1:0]);
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == READ) word_q <= bus.ram_rdata;
    end
  end
  always_comb begin
    state_nx = state == IDLE  ? (!accept ? IDLE :
                                 is_misaligned(bus.req_size, bus.req_addr[1:0]) ? RESP :
                                 bus.req_we && bus.req_size == SZ_WORD ? WRITE : READ) :
               state == READ  ? (we_q ? WRITE : RESP) :
               state == WRITE ? RESP : IDLE;
  end
  always_comb begin
    merged = word_q;
    if (size_q == SZ_BYTE) merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    else merged[16*addr_q[1] +: 16] = wdata_q[15:0];
  end
  load_align u_align (
    .word        (word_q),
    .addr        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_val)
  );
  assign bus.ram_we     = state == WRITE;
  assign bus.ram_addr   = (state == READ || state == WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.ram_wdata  = state != WRITE ? '0 : size_q == SZ_WORD ? wdata_q : merged;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_fault = state == RESP && fault_q;
  assign bus.resp_rdata = (state == RESP && !we_q && !fault_q) ? load_val : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, stores, faults and reset behaviour
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] mem [1024];
  mem_access_unit_if #(.ADDR_W(10)) bus ();
  mem_access_unit #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.ram_rdata = {mem[int'(bus.ram_addr) + 3], mem[int'(bus.ram_addr) + 2],
                          mem[int'(bus.ram_addr) + 1], mem[int'(bus.ram_addr)]};
  always @(posedge clk)
    if (bus.ram_we)
      for (int i = 0; i < 4; i++) mem[int'(bus.ram_addr) + i] <= bus.ram_wdata[8*i +: 8];

  task automatic preload();
    mem[16] = 8'hBB; mem[17] = 8'hAA; mem[18] = 8'h99; mem[19] = 8'h88;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [9:0] a,
                        input logic [31:0] wd, output int lat, output logic flt, output logic [31:0] rd,
                        output int wes, output int rds, output logic [9:0] wa, output logic [31:0] wdw);
    @(negedge clk);
    bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; flt = 1'bx; rd = 'x; wes = 0; rds = 0; wa = '0; wdw = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.ram_we) begin wes++; wa = bus.ram_addr; wdw = bus.ram_wdata; end
      else if (bus.ram_addr != '0) rds++;
      if (bus.resp_valid) begin lat = k; flt = bus.resp_fault; rd = bus.resp_rdata; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.ram_we} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl got ready/rv/rf/we=%b want 0000",
                        {bus.req_ready, bus.resp_valid, bus.resp_fault, bus.ram_we});
    end
    n_vec++;
    if ({bus.resp_rdata, bus.ram_wdata, bus.ram_addr} !== 74'b0) begin
      n_bad++; $display("FAIL reset_data got rdata=%h wdata=%h addr=%h want 0",
                        bus.resp_rdata, bus.ram_wdata, bus.ram_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] exp_d [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
    logic [1:0]  szs [4]   = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        us [4]    = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0]  as [4]    = '{10'h013, 10'h013, 10'h012, 10'h010};
    int lat, wes, rds; logic flt; logic [31:0] rd, wdw; logic [9:0] wa;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, szs[i], us[i], as[i], 32'h0, lat, flt, rd, wes, rds, wa, wdw);
      n_vec++;
      if (rd !== exp_d[i]) begin n_bad++; $display("FAIL load%0d_data got %h want %h", i, rd, exp_d[i]); end
      n_vec++;
      if ({lat, flt, wes} !== {32'd2, 1'b0, 32'd0}) begin
        n_bad++; $display("FAIL load%0d_timing got lat=%0d fault=%b we=%0d want 2 0 0", i, lat, flt, wes);
      end
    end
  endtask

  task automatic test_sub_store();
    int lat, wes, rds; logic flt; logic [31:0] rd, wdw; logic [9:0] wa;
    do_req(1'b1, 2'b00, 1'b0, 10'h011, 32'h000000CD, lat, flt, rd, wes, rds, wa, wdw);
    n_vec++;
    if ({wes, wa, wdw} !== {32'd1, 10'h010, 32'h8899CDBB}) begin
      n_bad++; $display("FAIL sb_write got we=%0d addr=%h wdata=%h want 1 010 8899cdbb", wes, wa, wdw);
    end
    n_vec++;
    if ({lat, flt, rd} !== {32'd3, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL sb_resp got lat=%0d fault=%b rdata=%h want 3 0 0", lat, flt, rd);
    end
    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, flt, rd, wes, rds, wa, wdw);
    n_vec++;
    if (rd !== 32'h8899CDBB) begin n_bad++; $display("FAIL sb_readback got %h want 8899cdbb", rd); end
  endtask

  task automatic test_word_store();
    int lat, wes, rds; logic flt; logic [31:0] rd, wdw; logic [9:0] wa;
    do_req(1'b1, 2'b10, 1'b0, 10'h020, 32'hDEADBEEF, lat, flt, rd, wes, rds, wa, wdw);
    n_vec++;
    if ({rds, wes, wa, wdw} !== {32'd0, 32'd1, 10'h020, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL sw_write got rd=%0d we=%0d addr=%h wdata=%h want 0 1 020 deadbeef", rds, wes, wa, wdw);
    end
    n_vec++;
    if ({lat, flt} !== {32'd2, 1'b0}) begin n_bad++; $display("FAIL sw_resp got lat=%0d fault=%b want 2 0", lat, flt); end
    do_req(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, lat, flt, rd, wes, rds, wa, wdw);
    n_vec++;
    if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_readback got %h want deadbeef", rd); end
  endtask

  task automatic test_faults();
    logic       wes_v [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0] szs [3]   = '{2'b10, 2'b01, 2'b11};
    logic [9:0] as [3]    = '{10'h022, 10'h021, 10'h020};
    int lat, wes, rds; logic flt; logic [31:0] rd, wdw; logic [9:0] wa;
    for (int i = 0; i < 3; i++) begin
      do_req(wes_v[i], szs[i], 1'b0, as[i], 32'h12345678, lat, flt, rd, wes, rds, wa, wdw);
      n_vec++;
      if ({flt, rd, lat} !== {1'b1, 32'h0, 32'd1}) begin
        n_bad++; $display("FAIL fault%0d_resp got fault=%b rdata=%h lat=%0d want 1 0 1", i, flt, rd, lat);
      end
      n_vec++;
      if ({wes, rds} !== 64'd0) begin n_bad++; $display("FAIL fault%0d_ram got we=%0d rd=%0d want 0 0", i, wes, rds); end
    end
    do_req(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, lat, flt, rd, wes, rds, wa, wdw);
    n_vec++;
    if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fault_ram_unchanged got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_mid();
    int wes = 0, rvs = 0, lat, rds; logic flt; logic [31:0] rd, wdw; logic [9:0] wa;
    preload();
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b01; bus.req_unsigned = 1'b0; bus.req_addr = 10'h010;
    bus.req_wdata = 32'h00001234; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.ram_addr !== 10'h010) begin n_bad++; $display("FAIL rmid_in_read got addr=%h want 010", bus.ram_addr); end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wes += int'(bus.ram_we); rvs += int'(bus.resp_valid);
      n_vec++;
      if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready_in_rst got %b want 0", bus.req_ready); end
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after got %b want 1", bus.req_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wes += int'(bus.ram_we); rvs += int'(bus.resp_valid);
    end
    n_vec++;
    if ({wes, rvs} !== 64'd0) begin n_bad++; $display("FAIL rmid_quiet got we=%0d rv=%0d want 0 0", wes, rvs); end
    do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, flt, rd, wes, rds, wa, wdw);
    n_vec++;
    if (rd !== 32'h8899AABB) begin n_bad++; $display("FAIL rmid_word got %h want 8899aabb", rd); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    preload();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_loads();
    test_sub_store();
    test_word_store();
    test_faults();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
